// File: rtl/input_frame_loader_if.sv
// input_frame_loader_if: pixel stream, memory write port and controller handshake of the frame loader
interface input_frame_loader_if #(
  parameter int PIX_W = 8,
  parameter int PIX_PER_WORD = 16,
  parameter int ADDR_W = 16
);
  logic pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic pix_last;
  logic pix_ready;
  logic image_done_pulse;
  logic input_mem_WE;
  logic [ADDR_W-1:0] input_mem_waddr;
  logic [PIX_W*PIX_PER_WORD-1:0] input_mem_wdata;
  logic new_image_pulse;
  logic [ADDR_W:0] input_mem_depth;
  logic overflow_fault;
  logic busy;
  modport master (
    output pix_valid, pix_data, pix_last, image_done_pulse,
    input pix_ready, input_mem_WE, input_mem_waddr, input_mem_wdata,
    input new_image_pulse, input_mem_depth, overflow_fault, busy
  );
  modport slave (
    input pix_valid, pix_data, pix_last, image_done_pulse,
    output pix_ready, input_mem_WE, input_mem_waddr, input_mem_wdata,
    output new_image_pulse, input_mem_depth, overflow_fault, busy
  );
endinterface

// File: rtl/input_frame_loader.sv
// input_frame_loader: packs a pixel stream into wide input-memory words and hands each finished frame to the controller
module input_frame_loader #(
  parameter int PIX_W = 8,
  parameter int PIX_PER_WORD = 16,
  parameter int ADDR_W = 16,
  parameter int MAX_WORDS = 65536
) (
  input logic clock,
  input logic reset,
  input_frame_loader_if.slave bus
);
  localparam int WORD_W = PIX_W * PIX_PER_WORD;
  localparam int LANE_W = $clog2(PIX_PER_WORD);
  typedef logic [ADDR_W:0] cnt_t;
  typedef logic [LANE_W-1:0] lane_t;
  localparam lane_t TOP_LANE = lane_t'(PIX_PER_WORD - 1);
  localparam cnt_t CAP = cnt_t'(MAX_WORDS);
  typedef enum logic [2:0] {IDLE, FILL, HANDOFF, WAIT_DONE, FAULT} state_t;
  state_t state_q, state_d;
  lane_t lane_q, lane_d;
  cnt_t word_cnt_q, word_cnt_d, depth_q, depth_d;
  logic [WORD_W-1:0] buf_q, buf_d, wdata_q, wdata_d, word;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic we_q, we_d, pulse_q, pulse_d, fault_q, fault_d;
  logic pix_ready, accept, word_due;
  assign pix_ready = state_q == IDLE || state_q == FILL;
  always_comb begin
    accept = bus.pix_valid && pix_ready;
    word_due = accept && (bus.pix_last || lane_q == TOP_LANE);
    word = buf_q | (WORD_W'(bus.pix_data) << (PIX_W * lane_q));
    state_d = state_q;
    lane_d = accept ? (lane_q == TOP_LANE ? '0 : lane_q + 1'b1) : lane_q;
    buf_d = accept ? (word_due ? '0 : word) : buf_q;
    word_cnt_d = word_cnt_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pulse_d = 1'b0;
    depth_d = depth_q;
    fault_d = fault_q;
    if (accept && state_q == IDLE) state_d = FILL;
    // a word due with memory already full is dropped and the frame is abandoned
    if (word_due && word_cnt_q == CAP) begin
      state_d = FAULT;
      fault_d = 1'b1;
    end else if (word_due) begin
      we_d = 1'b1;
      waddr_d = word_cnt_q[ADDR_W-1:0];
      wdata_d = word;
      word_cnt_d = word_cnt_q + 1'b1;
      if (bus.pix_last) state_d = HANDOFF;
    end
    if (state_q == HANDOFF) begin
      state_d = WAIT_DONE;
      pulse_d = 1'b1;
      depth_d = word_cnt_q;
    end
    if (state_q == WAIT_DONE && bus.image_done_pulse) begin
      state_d = IDLE;
      word_cnt_d = '0;
      lane_d = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q <= '0;
      word_cnt_q <= '0;
      buf_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pulse_q <= 1'b0;
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      word_cnt_q <= word_cnt_d;
      buf_q <= buf_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pulse_q <= pulse_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end
  assign bus.pix_ready = pix_ready;
  assign bus.input_mem_WE = we_q;
  assign bus.input_mem_waddr = waddr_q;
  assign bus.input_mem_wdata = wdata_q;
  assign bus.new_image_pulse = pulse_q;
  assign bus.input_mem_depth = depth_q;
  assign bus.overflow_fault = fault_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: doc/input_frame_loader.md
Name: input_frame_loader

Overview:
- Upstream neighbour of the mem_controller / top_level_control pair.
- Accepts a raster stream of 8-bit pixels with a valid/ready handshake and packs 16 pixels into each 128-bit word.
- Writes the packed words sequentially into input memory from address 0.
- At end of frame, publishes the word count on input_mem_depth and fires new_image_pulse, then holds off the next frame until image_done_pulse.

Parameters:
- PIX_W, 8, pixel width in bits.
- PIX_PER_WORD, 16, pixels packed per memory word (word width = PIX_W*PIX_PER_WORD = 128).
- ADDR_W, 16, input memory address width.
- MAX_WORDS, 65536, input memory capacity in words; at most 2^ADDR_W.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  stream pixel valid.
- pix_data  in  8  stream pixel value.
- pix_last  in  1  qualifies the final pixel of the frame; meaningful only while pix_valid=1.
- pix_ready  out  1  loader can accept a pixel this cycle.
- image_done_pulse  in  1  from top_level_control; the current frame has been fully processed.
- input_mem_WE  out  1  input memory write enable.
- input_mem_waddr  out  16  input memory write address.
- input_mem_wdata  out  128  input memory write data.
- new_image_pulse  out  1  one-cycle start strobe to top_level_control.
- input_mem_depth  out  17  number of words written for the last completed frame.
- overflow_fault  out  1  sticky frame-too-large fault.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values (any cycle, including mid-frame): state=IDLE, lane=0, word_cnt=0, input_mem_WE=0, input_mem_waddr=0, input_mem_wdata=0, new_image_pulse=0, input_mem_depth=0, overflow_fault=0, busy=0. Any partial word is discarded.
- States:
  - IDLE: pix_ready=1; first accepted pixel moves to FILL.
  - FILL: pix_ready=1; accepted pixel with pix_last=1 moves to HANDOFF.
  - HANDOFF: pix_ready=0; lasts exactly one cycle, then moves to WAIT_DONE.
  - WAIT_DONE: pix_ready=0; image_done_pulse=1 moves to IDLE and clears word_cnt and lane.
  - FAULT: pix_ready=0; exited only by reset.
- Accept: a pixel is accepted when pix_valid && pix_ready.
- Packing: pixel at lane k occupies bits [8k+7:8k], so lane 0 is the LSB. lane increments per accepted pixel and wraps 15->0.
- Word write, triggered by an accepted pixel at lane 15, or by an accepted pix_last at any lane:
  - Unfilled lanes above the last pixel are zero.
  - input_mem_WE=1 for exactly one cycle, in the cycle after the accepting edge.
  - input_mem_waddr = word_cnt at the time of the write; word_cnt then increments.
  - input_mem_wdata and input_mem_waddr hold their last values while WE=0.
- Handoff timing:
  - Last pixel accepted at edge N: final write has WE high in cycle N+1 (the HANDOFF cycle).
  - In cycle N+2: new_image_pulse=1 for one cycle, and input_mem_depth = total words written, in the range 1..MAX_WORDS.
  - input_mem_depth holds until the next frame's handoff.
- image_done_pulse:
  - Ignored in IDLE, FILL, HANDOFF and FAULT.
  - Honoured in the same cycle as new_image_pulse (state is already WAIT_DONE); the loader returns to IDLE the next cycle.
- Overflow:
  - If a word write is due while word_cnt == MAX_WORDS, no write occurs.
  - overflow_fault is set (sticky), state goes to FAULT, and new_image_pulse is never issued.
  - A frame of exactly MAX_WORDS words completes normally with input_mem_depth = MAX_WORDS (needs the 17th bit at the default).
- A frame is never zero words; pix_last on the very first pixel gives depth 1.
- Simultaneous pix_last at lane 15 produces a single write (a full word, no padding).
- Throughput: one pixel per cycle sustained; no bubbles between frames except HANDOFF and WAIT_DONE.

Test Plan:
1. 32 pixels with values 0..31, pix_valid held high, pix_last on pixel 31.
   -> Write addr0 data 0x0F0E..0100 and write addr1 data 0x1F1E..1110.
   -> new_image_pulse 2 cycles after the last accept; input_mem_depth=2.
2. 20 pixels with values 0xA0..0xB3.
   -> addr1 data = 0x...00_B3_B2_B1_B0 with lanes 4..15 zero; depth=2.
3. Single pixel 0x55 with pix_last.
   -> One write, addr0 data 0x55; depth=1; pix_ready=0 until image_done_pulse, then 1 the next cycle.
4. Random pix_valid gaps across a 48-pixel frame, plus image_done_pulse asserted in FILL.
   -> Packed data is identical to the gap-free case; image_done_pulse is ignored; depth=3.
5. MAX_WORDS=4, 80-pixel frame.
   -> 4 writes at addr 0..3, then overflow_fault=1 and pix_ready=0.
   -> No new_image_pulse; reset clears the fault.
6. Reset asserted after pixel 10 of a frame.
   -> All outputs at reset values the next cycle, no write issued.
   -> A following 16-pixel frame writes addr0 with depth=1.
